// File: rtl/square_tone_voice_tick_divider.sv
// Purpose : free-running prescaler; emits a one-cycle tick each time the count wraps.
// Latency : TICK_OUT is registered, high for the one cycle after the edge where count==MAX.
// Flow    : no backpressure; ENABLE_IN=0 freezes the count and keeps TICK_OUT low.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET_N    in   asynchronous active-low reset (count=0, TICK_OUT=0)
//   ENABLE_IN  in   1 = count advances this clock
//   TICK_OUT   out  registered one-cycle pulse, one per MAX+1 enabled clocks
module tick_divider #(
  parameter int WIDTH = 7,
  parameter int MAX   = 127
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENABLE_IN,
  output logic TICK_OUT
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count    <= '0;
      TICK_OUT <= 1'b0;
    end else if (ENABLE_IN) begin
      if (count == MaxCount) begin
        count    <= '0;
        TICK_OUT <= 1'b1;
      end else begin
        count    <= count + 1'b1;
        TICK_OUT <= 1'b0;
      end
    end else begin
      // A frozen divider must not leave a stale tick asserted.
      TICK_OUT <= 1'b0;
    end
  end

endmodule

// File: rtl/square_tone_voice.sv
// Purpose : single-voice square-wave generator; AUDIO toggles every HALF_PERIOD sample ticks.
// Latency : AUDIO changes on the edge that samples SAMPLE_TICK=1; silence clears on the next edge.
// Flow    : no backpressure; the prescaler always runs, ENABLE only gates the phase counter.
//
// Ports:
//   CLK          in   clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   ENABLE       in   1 = tone running, 0 = silence
//   HALF_PERIOD  in   half period in sample ticks; 0 = silence
//   AUDIO        out  registered square wave
//   SAMPLE_TICK  out  registered prescaler tick, one cycle every SAMPLE_DIV_MAX+1 clocks
module square_tone_voice #(
  parameter int SAMPLE_DIV_WIDTH = 7,
  parameter int SAMPLE_DIV_MAX   = 127,
  parameter int PERIOD_WIDTH     = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    ENABLE,
  input  logic [PERIOD_WIDTH-1:0] HALF_PERIOD,
  output logic                    AUDIO,
  output logic                    SAMPLE_TICK
);

  logic                    sampleTick;
  logic                    silent;
  logic [PERIOD_WIDTH-1:0] lastPhase;
  logic [PERIOD_WIDTH-1:0] phase;
  logic [PERIOD_WIDTH-1:0] phaseNext;
  logic                    audioNext;

  // Divider is exported so the sequencer can share the same sample rate.
  tick_divider #(
    .WIDTH (SAMPLE_DIV_WIDTH),
    .MAX   (SAMPLE_DIV_MAX)
  ) sampleDiv (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .ENABLE_IN (1'b1),
    .TICK_OUT  (sampleTick)
  );

  assign SAMPLE_TICK = sampleTick;

  assign silent = !ENABLE || (HALF_PERIOD == '0);

  // HALF_PERIOD-1 only matters when HALF_PERIOD is nonzero, so it never underflows.
  assign lastPhase = silent ? '0 : (HALF_PERIOD - 1'b1);

  always_comb begin
    phaseNext = phase;
    audioNext = AUDIO;
    if (silent) begin
      phaseNext = '0;
      audioNext = 1'b0;
    end else if (sampleTick) begin
      // >= rather than == so a shortened HALF_PERIOD mid-period toggles on the
      // next tick instead of letting phase run all the way around.
      if (phase >= lastPhase) begin
        phaseNext = '0;
        audioNext = ~AUDIO;
      end else begin
        phaseNext = phase + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase <= '0;
      AUDIO <= 1'b0;
    end else begin
      phase <= phaseNext;
      AUDIO <= audioNext;
    end
  end

endmodule

// File: tb/tb_square_tone_voice.sv
module tb_square_tone_voice;

  typedef struct {
    int    which;   // 0 = small-divider DUT, 1 = default-parameter DUT
    int    cyc;     // posedge count at which the outputs are sampled
    logic  audio;
    logic  tick;
    string name;
  } expT;

  logic        CLK;
  logic        rstN;
  logic        en;
  logic [15:0] hp;
  logic        audio;
  logic        tick;

  logic        rstDefN;
  logic        enDef;
  logic [15:0] hpDef;
  logic        audioDef;
  logic        tickDef;

  expT expQ[$];
  int  cyc;
  int  total;
  int  bad;
  bit  drainReq;
  bit  drainAck;
  expT e;

  square_tone_voice #(
    .SAMPLE_DIV_WIDTH (2),
    .SAMPLE_DIV_MAX   (3),
    .PERIOD_WIDTH     (16)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (rstN),
    .ENABLE      (en),
    .HALF_PERIOD (hp),
    .AUDIO       (audio),
    .SAMPLE_TICK (tick)
  );

  square_tone_voice dutDef (
    .CLK         (CLK),
    .RESET_N     (rstDefN),
    .ENABLE      (enDef),
    .HALF_PERIOD (hpDef),
    .AUDIO       (audioDef),
    .SAMPLE_TICK (tickDef)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this cycle and compares.
  always @(negedge CLK) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      e = expQ.pop_front();
      total = total + 1;
      if (e.cyc < cyc) begin
        bad = bad + 1;
        $display("FAIL %s missed: due cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (e.which == 0) begin
        if (audio !== e.audio || tick !== e.tick) begin
          bad = bad + 1;
          $display("FAIL %s cyc=%0d audio/tick got=%b/%b want=%b/%b",
                   e.name, cyc, audio, tick, e.audio, e.tick);
        end
      end else begin
        if (audioDef !== e.audio || tickDef !== e.tick) begin
          bad = bad + 1;
          $display("FAIL %s cyc=%0d audio/tick got=%b/%b want=%b/%b",
                   e.name, cyc, audioDef, tickDef, e.audio, e.tick);
        end
      end
    end
    if (drainReq && !drainAck) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        total = total + 1;
        bad = bad + 1;
        $display("FAIL %s never checked: due cyc=%0d", e.name, e.cyc);
      end
      drainAck = 1'b1;
    end
  end

  task automatic pushExp(input int which, input int c, input logic a,
                         input logic t, input string nm);
    expT x;
    x.which = which;
    x.cyc   = c;
    x.audio = a;
    x.tick  = t;
    x.name  = nm;
    expQ.push_back(x);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Hold reset a few clocks with the given inputs, then release; returns the base cycle.
  task automatic resetRelease(input logic enV, input logic [15:0] hpV, output int base);
    rstN = 1'b0;
    waitEdges(3);
    en   = enV;
    hp   = hpV;
    rstN = 1'b1;
    base = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int baseD;
    cyc      = 0;
    total    = 0;
    bad      = 0;
    drainReq = 1'b0;
    drainAck = 1'b0;
    rstN     = 1'b0;
    en       = 1'b0;
    hp       = '0;
    rstDefN  = 1'b0;
    enDef    = 1'b0;
    hpDef    = '0;

    waitEdges(2);
    // Reset state while RESET_N is held low.
    pushExp(0, cyc, 1'b0, 1'b0, "reset_state");
    pushExp(1, cyc, 1'b0, 1'b0, "reset_state_def");
    waitEdges(1);

    // Disabled: prescaler still ticks on cycles 4,8,..,20; AUDIO stays low.
    resetRelease(1'b0, 16'd0, base);
    for (int k = 1; k <= 20; k++)
      pushExp(0, base + k, 1'b0, (k % 4) == 0, "idle_tick");
    waitEdges(21);

    // HALF_PERIOD=2: ticks sampled at edges 5,9,..; toggles at edges 9,17,25,..
    resetRelease(1'b1, 16'd2, base);
    for (int k = 1; k <= 160; k++)
      pushExp(0, base + k, ((k - 1) / 8) % 2 == 1, (k % 4) == 0, "hp2_wave");
    waitEdges(161);

    // HALF_PERIOD=0 is silence even with ENABLE high.
    resetRelease(1'b1, 16'd0, base);
    for (int k = 1; k <= 100; k++)
      pushExp(0, base + k, 1'b0, (k % 4) == 0, "hp0_silent");
    waitEdges(100);
    // HALF_PERIOD=1: tick of cycle 100 is sampled at edge 101, then every tick toggles.
    hp = 16'd1;
    for (int k = 101; k <= 140; k++)
      pushExp(0, base + k, ((k - 101) / 4) % 2 == 0, (k % 4) == 0, "hp1_wave");
    waitEdges(41);

    // HALF_PERIOD=5 reaches phase=3 after edge 13; switching to 2 toggles at edge 17.
    resetRelease(1'b1, 16'd5, base);
    for (int k = 1; k <= 40; k++)
      pushExp(0, base + k, (k >= 17) && (((k - 17) / 8) % 2 == 0), (k % 4) == 0,
              "hp_shrink");
    waitEdges(13);
    hp = 16'd2;
    waitEdges(27);

    // AUDIO is 1 here; dropping ENABLE clears it on the next edge.
    en = 1'b0;
    for (int k = 41; k <= 51; k++)
      pushExp(0, base + k, k >= 49, (k % 4) == 0, "disable_reenable");
    waitEdges(4);
    // Re-enabled after edge 44: ticks sampled at 45 (phase 1) and 49 (rise).
    en = 1'b1;
    waitEdges(8);

    // Cycle 52: AUDIO=1 and SAMPLE_TICK=1; async reset must clear both before any edge.
    rstN = 1'b0;
    pushExp(0, base + 52, 1'b0, 1'b0, "async_reset");
    waitEdges(2);

    // Default divider (128 clocks/tick), HALF_PERIOD=2: 512-clock period.
    enDef   = 1'b1;
    hpDef   = 16'd2;
    rstDefN = 1'b1;
    baseD   = cyc;
    pushExp(1, baseD + 127,  1'b0, 1'b0, "def_tick_pre");
    pushExp(1, baseD + 128,  1'b0, 1'b1, "def_tick");
    pushExp(1, baseD + 129,  1'b0, 1'b0, "def_tick_post");
    pushExp(1, baseD + 256,  1'b0, 1'b1, "def_pre_rise");
    pushExp(1, baseD + 257,  1'b1, 1'b0, "def_rise");
    pushExp(1, baseD + 512,  1'b1, 1'b1, "def_pre_fall");
    pushExp(1, baseD + 513,  1'b0, 1'b0, "def_fall");
    pushExp(1, baseD + 768,  1'b0, 1'b1, "def_pre_rise2");
    pushExp(1, baseD + 769,  1'b1, 1'b0, "def_rise2");
    pushExp(1, baseD + 1024, 1'b1, 1'b1, "def_pre_fall2");
    pushExp(1, baseD + 1025, 1'b0, 1'b0, "def_fall2");
    waitEdges(1027);

    drainReq = 1'b1;
    for (int i = 0; i < 10 && !drainAck; i++) @(posedge CLK);
    #1;
    if (!drainAck) $display("FAIL drain: monitor did not acknowledge");
    $display("test done: total=%0d bad=%0d", total, drainAck ? bad : bad + 1);
    $finish;
  end

endmodule

// File: doc/square_tone_voice.md
Name: square_tone_voice

Overview:
- Single-voice square-wave tone generator for the audio path.
- Contains a free-running prescaler that emits a one-cycle advance tick every SAMPLE_DIV_MAX+1 clocks.
- A half-period counter consumes those ticks and toggles a 1-bit AUDIO output every HALF_PERIOD ticks.
- A sequencer upstream drives ENABLE and HALF_PERIOD; AUDIO goes straight to the PWM/audio pin.

Parameters:
- SAMPLE_DIV_WIDTH, 7, width of the prescaler count register.
- SAMPLE_DIV_MAX, 127, terminal prescaler count; tick period is SAMPLE_DIV_MAX+1 clocks. Must fit in SAMPLE_DIV_WIDTH bits.
- PERIOD_WIDTH, 16, width of HALF_PERIOD and of the phase counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  1 = tone running; 0 = silence.
- HALF_PERIOD  in  PERIOD_WIDTH  half period in advance ticks; 0 = silence.
- AUDIO  out  1  square-wave output, registered.
- SAMPLE_TICK  out  1  prescaler tick, one-cycle pulse, registered; provided for observation and sharing.

Behaviour:
- Reset (RESET_N=0, asynchronous): prescaler count=0, SAMPLE_TICK=0, phase=0, AUDIO=0. Outputs are held there while RESET_N is low.
- Prescaler:
  - count increments by 1 each clock.
  - At count==SAMPLE_DIV_MAX, count wraps to 0 and SAMPLE_TICK is registered high for the next cycle only.
  - First SAMPLE_TICK occurs in cycle SAMPLE_DIV_MAX+1 after reset release. Thereafter exactly one pulse per SAMPLE_DIV_MAX+1 clocks.
  - The prescaler is never gated by ENABLE.
- Silence condition: ENABLE==0 or HALF_PERIOD==0.
  - On every clock in silence, phase<=0 and AUDIO<=0, regardless of SAMPLE_TICK.
- Running, cycle with SAMPLE_TICK==1:
  - If phase >= HALF_PERIOD-1: phase<=0 and AUDIO<=~AUDIO.
  - Otherwise phase<=phase+1.
- Running, cycle with SAMPLE_TICK==0: phase and AUDIO hold.
- Resulting period: AUDIO toggles every HALF_PERIOD ticks, so the full period is 2*HALF_PERIOD*(SAMPLE_DIV_MAX+1) clocks.
  - HALF_PERIOD=1 toggles on every tick.
- Latency: AUDIO changes on the same clock edge that samples the SAMPLE_TICK=1 cycle.
- HALF_PERIOD changed mid-period:
  - The new value applies from the next tick.
  - If phase already >= new HALF_PERIOD-1, AUDIO toggles on the next tick (the >= compare prevents runaway wrap).
  - AUDIO keeps its current level; no phase reset.
- Leaving silence: phase=0 and AUDIO=0, so the first toggle (to 1) occurs HALF_PERIOD ticks after ENABLE rises with HALF_PERIOD nonzero.
- Reset asserted mid-tone: immediate return to reset values. After release, behaviour is identical to power-up.
- Arithmetic: HALF_PERIOD-1 is computed only when HALF_PERIOD!=0, so no underflow. Phase never exceeds 2^PERIOD_WIDTH-2.

Decomposition:
- No shared package needed. Parameters are local; no typedefs.
- One sub-module: tick_divider.
  - Parameters WIDTH and MAX.
  - Ports CLK, RESET_N, ENABLE_IN, TICK_OUT.
  - Counts when ENABLE_IN=1 and emits a registered one-cycle tick on wrap.
  - Instantiated with ENABLE_IN tied to 1.
  - Reusable by the sequencer for its own slower step tick.
- The phase/toggle logic lives in square_tone_voice.

Test Plan:
- Use SAMPLE_DIV_MAX=3 unless stated otherwise.
- Reset, then run 20 clocks with ENABLE=0 -> SAMPLE_TICK pulses in cycles 4, 8, 12, 16, 20 after release; AUDIO stays 0.
- ENABLE=1, HALF_PERIOD=2 from reset -> AUDIO rises after 8 clocks, then toggles every 8 clocks (16-clock period) across 10 periods.
- ENABLE=1, HALF_PERIOD=0 for 100 clocks -> AUDIO=0 and phase=0 throughout; then HALF_PERIOD=1 -> AUDIO toggles on every tick (4 clocks).
- Running with HALF_PERIOD=5 and phase=3, switch HALF_PERIOD to 2 -> toggle on the next tick, then every 2 ticks.
- AUDIO=1 mid-tone, drive ENABLE=0 -> AUDIO=0 on the next edge; re-enable -> first rise HALF_PERIOD ticks later.
- Assert RESET_N low asynchronously between edges while AUDIO=1 -> AUDIO and SAMPLE_TICK go 0 immediately.
- Default parameters (SAMPLE_DIV_MAX=127), HALF_PERIOD=2 -> AUDIO period 512 clocks.
